// File: rtl/text_console.sv
// Character-stream writer for the text-mode display: cursor, CR/LF/BS handling, wrap and row clearing.
// Build option: define TEXT_CONSOLE_CLEAR_EN to clear the whole screen after reset.
module text_console #(
    parameter int         TextCols  = 64,
    parameter int         TextRows  = 32,
    parameter logic [7:0] ClearChar = 8'h20
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [7:0]                           in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [$clog2(TextCols*TextRows)-1:0] TEXT_A,
    output logic [7:0]                           TEXT_D,
    output logic                                 TEXT_WE,
    output logic [$clog2(TextCols)-1:0]          cursor_col,
    output logic [$clog2(TextRows)-1:0]          cursor_row
);
    localparam int AW = $clog2(TextCols * TextRows);
    localparam int CW = $clog2(TextCols);
    localparam int RW = $clog2(TextRows);
    localparam int NW = AW + 1;

    localparam logic [NW-1:0] LineCells   = NW'(TextCols);
    localparam logic [NW-1:0] ScreenCells = NW'(TextCols * TextRows);
    localparam logic [CW-1:0] LastCol     = CW'(TextCols - 1);
    localparam logic [RW-1:0] LastRow     = RW'(TextRows - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_CLEAR,
        S_IDLE,
        S_LINE_CLR
    } state_t;

    state_t        state_reg;
    logic [NW-1:0] cnt_reg;
    logic [RW-1:0] next_row;
    logic [AW-1:0] row_base;
    logic [AW-1:0] next_row_base;
    logic [AW-1:0] cur_addr;

    assign next_row      = (cursor_row == LastRow) ? '0 : cursor_row + 1'b1;
    assign row_base      = AW'(cursor_row) * AW'(TextCols);
    assign next_row_base = AW'(next_row) * AW'(TextCols);
    assign cur_addr      = row_base + AW'(cursor_col);
    assign in_ready      = (state_reg == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_INIT;
            cnt_reg    <= '0;
            TEXT_WE    <= 1'b0;
            TEXT_A     <= '0;
            TEXT_D     <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
        end else begin
            TEXT_WE <= 1'b0;
            case (state_reg)
                S_INIT: begin
`ifdef TEXT_CONSOLE_CLEAR_EN
                    TEXT_WE   <= 1'b1;
                    TEXT_A    <= '0;
                    TEXT_D    <= ClearChar;
                    cnt_reg   <= NW'(1);
                    state_reg <= S_CLEAR;
`else
                    state_reg <= S_IDLE;
`endif
                end

                // The counter runs one past the last cell so in_ready rises only
                // after the final clear write has been presented.
                S_CLEAR: begin
                    if (cnt_reg == ScreenCells) begin
                        state_reg <= S_IDLE;
                    end else begin
                        TEXT_WE <= 1'b1;
                        TEXT_A  <= AW'(cnt_reg);
                        TEXT_D  <= ClearChar;
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                // cursor_row already points at the incoming row here.
                S_LINE_CLR: begin
                    if (cnt_reg == LineCells) begin
                        state_reg <= S_IDLE;
                    end else begin
                        TEXT_WE <= 1'b1;
                        TEXT_A  <= row_base + AW'(cnt_reg);
                        TEXT_D  <= ClearChar;
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                S_IDLE: begin
                    if (in_valid) begin
                        case (in_data)
                            8'h0D: cursor_col <= '0;
                            8'h0A: begin
                                // An LF issues its first clear write right away.
                                cursor_col <= '0;
                                cursor_row <= next_row;
                                TEXT_WE    <= 1'b1;
                                TEXT_A     <= next_row_base;
                                TEXT_D     <= ClearChar;
                                cnt_reg    <= NW'(1);
                                state_reg  <= S_LINE_CLR;
                            end
                            8'h08: begin
                                if (cursor_col != '0) begin
                                    cursor_col <= cursor_col - 1'b1;
                                    TEXT_WE    <= 1'b1;
                                    TEXT_A     <= cur_addr - 1'b1;
                                    TEXT_D     <= ClearChar;
                                end
                            end
                            default: begin
                                TEXT_WE <= 1'b1;
                                TEXT_A  <= cur_addr;
                                TEXT_D  <= in_data;
                                if (cursor_col == LastCol) begin
                                    cursor_col <= '0;
                                    cursor_row <= next_row;
                                    cnt_reg    <= '0;
                                    state_reg  <= S_LINE_CLR;
                                end else begin
                                    cursor_col <= cursor_col + 1'b1;
                                end
                            end
                        endcase
                    end
                end

                default: state_reg <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console: queue-based screen model checked every cycle,
// plus directed byte sequences with literal expectations.
module tb_text_console;
    localparam int Cols = 64;
    localparam int Rows = 32;
`ifdef TEXT_CONSOLE_CLEAR_EN
    localparam bit ClearEn = 1'b1;
`else
    localparam bit ClearEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] TEXT_A;
    logic [7:0]  TEXT_D;
    logic        TEXT_WE;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;

    text_console dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .TEXT_A    (TEXT_A),
        .TEXT_D    (TEXT_D),
        .TEXT_WE   (TEXT_WE),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit live = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Writes are queued in presentation order (one per cycle); busy counts
    // the cycles the console refuses input.
    int m_col, m_row, m_busy;
    bit m_init;
    int wq_a[$];
    int wq_d[$];
    bit exp_we, exp_ready;
    int exp_a, exp_d;

    task automatic push_w(input int a, input int d);
        wq_a.push_back(a);
        wq_d.push_back(d);
    endtask

    task automatic m_newline();
        m_col = 0;
        m_row = (m_row + 1) % Rows;
        for (int i = 0; i < Cols; i++) push_w(m_row * Cols + i, 32'h20);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                wq_a.delete();
                wq_d.delete();
                m_col = 0; m_row = 0; m_busy = 0; m_init = 1'b1;
                exp_we = 1'b0; exp_a = 0; exp_d = 0; exp_ready = 1'b0;
                live = 1'b1;
            end else begin
                if (m_init) begin
                    m_init = 1'b0;
                    if (ClearEn) begin
                        for (int i = 0; i < Cols * Rows; i++) push_w(i, 32'h20);
                        m_busy = Cols * Rows;
                    end
                end else if (exp_ready && in_valid) begin
                    case (in_data)
                        8'h0D: m_col = 0;
                        8'h0A: begin m_newline(); m_busy = Cols; end
                        8'h08: if (m_col > 0) begin
                            m_col--;
                            push_w(m_row * Cols + m_col, 32'h20);
                        end
                        default: begin
                            push_w(m_row * Cols + m_col, int'(in_data));
                            if (m_col == Cols - 1) begin
                                m_newline();
                                m_busy = Cols + 1;
                            end else begin
                                m_col++;
                            end
                        end
                    endcase
                end
                if (wq_a.size() > 0) begin
                    exp_we = 1'b1;
                    exp_a = wq_a.pop_front();
                    exp_d = wq_d.pop_front();
                end else begin
                    exp_we = 1'b0;
                end
                if (m_busy > 0) begin
                    exp_ready = 1'b0;
                    m_busy--;
                end else begin
                    exp_ready = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare + write log ----------------
    int log_a[$];
    int log_d[$];
    int log_c[$];

    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                chk("we", 32'(TEXT_WE), 32'(exp_we));
                if (exp_we) begin
                    chk("addr", 32'(TEXT_A), exp_a);
                    chk("data", 32'(TEXT_D), exp_d);
                end
                chk("ready", 32'(in_ready), 32'(exp_ready));
                chk("col", 32'(cursor_col), m_col);
                chk("row", 32'(cursor_row), m_row);
            end
            if (TEXT_WE === 1'b1) begin
                log_a.push_back(int'(TEXT_A));
                log_d.push_back(int'(TEXT_D));
                log_c.push_back(cyc);
            end
        end
    end

    function automatic int la(input int i);
        return (i >= 0 && i < log_a.size()) ? log_a[i] : -1;
    endfunction
    function automatic int ld(input int i);
        return (i >= 0 && i < log_d.size()) ? log_d[i] : -1;
    endfunction
    function automatic int lc(input int i);
        return (i >= 0 && i < log_c.size()) ? log_c[i] : -1;
    endfunction

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input string name, input int limit);
        int waited = 0;
        while (in_ready !== 1'b1 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        chk(name, 32'(waited < limit), 32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        in_data = b;
        in_valid = 1'b1;
        wait_ready("send_wait", 200);
        @(negedge clk);
        in_valid = 1'b0;
        $display("tx 0x%02h -> cursor col=%0d row=%0d", b, cursor_col, cursor_row);
    endtask

    int n;
    int good;

    initial begin
        reset = 1'b1;
        tick(3);
        chk("rst_we", 32'(TEXT_WE), 32'd0);
        chk("rst_a", 32'(TEXT_A), 32'd0);
        chk("rst_d", 32'(TEXT_D), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_col", 32'(cursor_col), 32'd0);
        chk("rst_row", 32'(cursor_row), 32'd0);

        n = log_a.size();
        reset = 1'b0;
        tick(1);
        chk("init_ready", 32'(in_ready), 32'(!ClearEn));
        wait_ready("init_wait", 3000);
        tick(1);
        good = 0;
        for (int i = 0; i < log_a.size() - n; i++)
            if (la(n + i) == i && ld(n + i) == 32'h20) good++;
        chk("init_clear_writes", 32'(log_a.size() - n), ClearEn ? 32'd2048 : 32'd0);
        chk("init_clear_inorder", 32'(good), ClearEn ? 32'd2048 : 32'd0);

        // "A","B" back-to-back
        n = log_a.size();
        send(8'h41);
        send(8'h42);
        tick(1);
        chk("ab_a0", 32'(la(n)), 32'd0);
        chk("ab_d0", 32'(ld(n)), 32'h41);
        chk("ab_a1", 32'(la(n + 1)), 32'd1);
        chk("ab_d1", 32'(ld(n + 1)), 32'h42);
        chk("ab_consecutive", 32'(lc(n + 1) - lc(n)), 32'd1);
        chk("ab_col", 32'(cursor_col), 32'd2);

        // 64 printable bytes from (0,0) wrap onto row 1
        send(8'h0D);
        n = log_a.size();
        for (int i = 0; i < 64; i++) send(8'(33 + i));
        wait_ready("wrap_wait", 200);
        tick(1);
        chk("wrap_count", 32'(log_a.size() - n), 32'd128);
        chk("wrap_last_a", 32'(la(n + 63)), 32'd63);
        chk("wrap_last_d", 32'(ld(n + 63)), 32'h60);
        chk("wrap_clr_first", 32'(la(n + 64)), 32'd64);
        chk("wrap_clr_last", 32'(la(n + 127)), 32'd127);
        chk("wrap_clr_d", 32'(ld(n + 127)), 32'h20);
        chk("wrap_col", 32'(cursor_col), 32'd0);
        chk("wrap_row", 32'(cursor_row), 32'd1);

        // BS at (3,2)
        send(8'h0A);
        wait_ready("lf_wait", 200);
        send(8'h78); send(8'h79); send(8'h7A);
        n = log_a.size();
        send(8'h08);
        tick(1);
        chk("bs_count", 32'(log_a.size() - n), 32'd1);
        chk("bs_a", 32'(la(n)), 32'd130);
        chk("bs_d", 32'(ld(n)), 32'h20);
        chk("bs_col", 32'(cursor_col), 32'd2);

        // CR at column 7
        for (int i = 0; i < 5; i++) send(8'(97 + i));
        chk("cr_pre_col", 32'(cursor_col), 32'd7);
        n = log_a.size();
        send(8'h0D);
        tick(1);
        chk("cr_nowrite", 32'(log_a.size() - n), 32'd0);
        chk("cr_col", 32'(cursor_col), 32'd0);

        // BS at column 0 stays on the row
        n = log_a.size();
        send(8'h08);
        tick(1);
        chk("bs0_nowrite", 32'(log_a.size() - n), 32'd0);
        chk("bs0_row", 32'(cursor_row), 32'd2);

        // LF at row 31 col 5 wraps to row 0
        for (int i = 0; i < 29; i++) begin
            send(8'h0A);
            wait_ready("lf_wait", 200);
        end
        chk("row31", 32'(cursor_row), 32'd31);
        for (int i = 0; i < 5; i++) send(8'h2E);
        n = log_a.size();
        send(8'h0A);
        wait_ready("lf31_wait", 200);
        tick(1);
        chk("lf31_count", 32'(log_a.size() - n), 32'd64);
        chk("lf31_first", 32'(la(n)), 32'd0);
        chk("lf31_last", 32'(la(n + 63)), 32'd63);
        chk("lf31_col", 32'(cursor_col), 32'd0);
        chk("lf31_row", 32'(cursor_row), 32'd0);

        // BS at (0,0)
        n = log_a.size();
        send(8'h08);
        tick(1);
        chk("bs00_nowrite", 32'(log_a.size() - n), 32'd0);
        chk("bs00_col", 32'(cursor_col), 32'd0);

        // reset during the 10th cycle of a line clear
        n = log_a.size();
        send(8'h0A);
        tick(9);
        reset = 1'b1;
        tick(1);
        chk("mid_we", 32'(TEXT_WE), 32'd0);
        chk("mid_ready", 32'(in_ready), 32'd0);
        chk("mid_row", 32'(cursor_row), 32'd0);
        chk("mid_writes", 32'(log_a.size() - n), 32'd10);
        reset = 1'b0;
        tick(1);
        wait_ready("mid_wait", 3000);
        tick(1);
        chk("mid_after", 32'(log_a.size() - n), ClearEn ? 32'd2058 : 32'd10);
        chk("mid_col", 32'(cursor_col), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
